// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: turns one register-level command (register write, or
// pointer write followed by a repeated-start read burst) into the byte-by-byte
// ena/addr/rw/data_wr handshake of i2c_master, pacing on busy rising edges.
module i2c_txn_sequencer #(
  parameter int MAX_LEN = 6,
  parameter int LEN_W   = 4,
  parameter int TMO_CYC = 2000000
) (
  input  logic             clk_sys,
  input  logic             cpu_resetn,
  input  logic             cmd_start,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_dev,
  input  logic [7:0]       cmd_reg,
  input  logic [7:0]       cmd_wdata,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [LEN_W-1:0] rd_idx,
  output logic             done,
  output logic             err,
  output logic             i2c_ena,
  output logic [6:0]       i2c_addr,
  output logic             i2c_rw,
  output logic [7:0]       i2c_data_wr,
  input  logic             i2c_busy,
  input  logic [7:0]       i2c_data_rd,
  input  logic             i2c_ack_error
);

  // Byte counter needs one extra bit: a full burst is 1 + MAX_LEN bytes.
  localparam int CNT_W = LEN_W + 1;
  localparam int WD_W  = $clog2(TMO_CYC + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [WD_W-1:0]  TMO_V     = WD_W'(TMO_CYC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             err_q, err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic             busy_rise, busy_fall, tmo, abort_run;
  logic [CNT_W-1:0] k_inc;
  logic [LEN_W-1:0] len_clamped;

  assign busy_rise   = i2c_busy & ~busy_q;
  assign busy_fall   = ~i2c_busy & busy_q;
  assign tmo         = (wdog_q >= TMO_V);
  assign abort_run   = (i2c_ack_error & i2c_busy) | tmo;
  assign k_inc       = k_q + 1'b1;
  assign len_clamped = (cmd_len > MAX_LEN_V) ? MAX_LEN_V : cmd_len;

  assign rd_valid = rd_valid_q;
  assign rd_idx   = rd_idx_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

  // Next-state, byte pacing, read capture and bus-side outputs.
  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    len_d       = len_q;
    total_d     = total_q;
    k_d         = k_q;
    busy_d      = i2c_busy;
    wdog_d      = wdog_q;
    err_d       = err_q;
    rd_valid_d  = 1'b0;
    rd_idx_d    = rd_idx_q;
    rd_data_d   = rd_data_q;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    i2c_ena     = 1'b0;
    i2c_addr    = 7'd0;
    i2c_rw      = 1'b0;
    i2c_data_wr = 8'd0;

    // Watchdog runs in every non-idle state and saturates at the limit.
    if (state_q != S_IDLE && !tmo) begin
      wdog_d = wdog_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_start) begin
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          wdata_d = cmd_wdata;
          rw_d    = cmd_rw;
          len_d   = cmd_rw ? len_clamped : '0;
          total_d = cmd_rw ? (CNT_W'(len_clamped) + CNT_W'(1)) : CNT_W'(2);
          k_d     = '0;
          wdog_d  = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        i2c_ena     = 1'b1;
        i2c_addr    = dev_q;
        i2c_rw      = (k_q == '0) ? 1'b0 : rw_q;
        i2c_data_wr = (k_q == '0) ? reg_q : wdata_q;
        if (abort_run) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end else if (busy_rise) begin
          k_d = k_inc;
          // A new byte starting means the previous read byte is on data_rd.
          if (rw_q && k_q >= CNT_W'(2)) begin
            rd_valid_d = 1'b1;
            rd_idx_d   = LEN_W'(k_q - CNT_W'(2));
            rd_data_d  = i2c_data_rd;
          end
          if (k_inc == total_q) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (busy_fall) begin
          // Final read byte completes on the last busy fall.
          if (rw_q && len_q != '0 && !err_q) begin
            rd_valid_d = 1'b1;
            rd_idx_d   = len_q - LEN_W'(1);
            rd_data_d  = i2c_data_rd;
          end
        end else if (!i2c_busy && !busy_q) begin
          // One settled idle cycle so the last rd_valid precedes done.
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!cpu_resetn) begin
      state_q    <= S_IDLE;
      dev_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      len_q      <= '0;
      total_q    <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      len_q      <= len_d;
      total_q    <= total_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: behavioural i2c_master byte engine plus a
// table of commands with hand-computed bus/readback expectations.
module tb_i2c_txn_sequencer;

  localparam int BYTE_CYC = 8;
  localparam int NV       = 10;

  logic       clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       cpu_resetn;
  logic       cmd_start, cmd_ready, cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic [3:0] cmd_len;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] rd_idx;
  logic       done, err;
  logic       i2c_ena, i2c_rw, i2c_busy, i2c_ack_error;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data_wr, i2c_data_rd;

  i2c_txn_sequencer #(.MAX_LEN(6), .LEN_W(4), .TMO_CYC(500)) dut (
    .clk_sys(clk_sys), .cpu_resetn(cpu_resetn),
    .cmd_start(cmd_start), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .done(done), .err(err),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_wr(i2c_data_wr),
    .i2c_busy(i2c_busy), .i2c_data_rd(i2c_data_rd), .i2c_ack_error(i2c_ack_error)
  );

  // ---------------- i2c_master model ----------------
  logic       m_stuck, m_nack, m_active, m_cur_rw;
  int         m_cnt, m_rcnt;
  int         bus_n = 0;
  logic [6:0] log_addr [0:63];
  logic       log_rw   [0:63];
  logic [7:0] log_data [0:63];

  always @(posedge clk_sys) begin
    if (!cpu_resetn) begin
      i2c_busy      <= 1'b0;
      i2c_ack_error <= 1'b0;
      i2c_data_rd   <= 8'h00;
      m_active      <= 1'b0;
      m_cur_rw      <= 1'b0;
      m_cnt         <= 0;
      m_rcnt        <= 0;
    end else if (!i2c_busy) begin
      if (i2c_ena) begin
        i2c_busy             <= 1'b1;
        m_cnt                <= BYTE_CYC;
        m_cur_rw             <= i2c_rw;
        m_active             <= 1'b1;
        log_addr[bus_n % 64] <= i2c_addr;
        log_rw[bus_n % 64]   <= i2c_rw;
        log_data[bus_n % 64] <= i2c_data_wr;
        bus_n                <= bus_n + 1;
        if (!m_active) begin
          m_rcnt        <= 0;
          i2c_ack_error <= m_nack;
        end else begin
          i2c_ack_error <= 1'b0;
        end
      end else begin
        m_active <= 1'b0;
      end
    end else if (!m_stuck) begin
      if (m_cnt <= 1) begin
        i2c_busy <= 1'b0;
        if (m_cur_rw) begin
          i2c_data_rd <= 8'((m_rcnt + 1) * 17);
          m_rcnt      <= m_rcnt + 1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] regad;
    logic [7:0] wdata;
    logic [3:0] len;
    logic       nack;
    logic       stuck;
    int         poke;       // loop cycle at which a stray cmd_start is pulsed (-1 none)
    int         rst_after;  // reset once this many bytes were seen (-1 none)
    int         exp_rises;  // -1 = not checked
    int         exp_bytes;
    logic       exp_err;
    logic       exp_done;
  } vec_t;

  vec_t       vecs [NV];
  vec_t       t;
  int         base, nvalid, late, cnt_done;
  logic       got_done, done_err, was_reset;
  logic [3:0] cap_idx  [0:15];
  logic [7:0] cap_data [0:15];

  initial begin
    vecs[0] = '{1'b0, 7'h69, 8'h6B, 8'h00, 4'd0, 1'b0, 1'b0, -1, -1,  2, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 7'h69, 8'h3B, 8'h00, 4'd6, 1'b0, 1'b0, -1, -1,  7, 6, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 7'h69, 8'h3B, 8'h00, 4'd9, 1'b0, 1'b0, -1, -1,  7, 6, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 7'h69, 8'h3B, 8'h00, 4'd0, 1'b0, 1'b0, -1, -1,  1, 0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 7'h69, 8'h3B, 8'h00, 4'd6, 1'b1, 1'b0, -1, -1,  1, 0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 7'h69, 8'h3B, 8'h00, 4'd6, 1'b0, 1'b0, 20, -1,  7, 6, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 7'h69, 8'h3B, 8'h00, 4'd6, 1'b0, 1'b1, -1, -1,  1, 0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 7'h69, 8'h3B, 8'h00, 4'd6, 1'b0, 1'b0, -1,  3, -1, 3, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 7'h68, 8'h43, 8'h00, 4'd2, 1'b0, 1'b0, -1, -1,  3, 2, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 7'h69, 8'h1A, 8'h03, 4'd0, 1'b0, 1'b0, -1, -1,  2, 0, 1'b0, 1'b1};

    m_stuck    = 1'b0;
    m_nack     = 1'b0;
    cpu_resetn = 1'b0;
    cmd_start  = 1'b0;
    cmd_rw     = 1'b0;
    cmd_dev    = 7'h00;
    cmd_reg    = 8'h00;
    cmd_wdata  = 8'h00;
    cmd_len    = 4'd0;
    repeat (3) @(negedge clk_sys);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ena", i2c_ena, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    cpu_resetn = 1'b1;
    repeat (2) @(negedge clk_sys);

    for (int v = 0; v < NV; v++) begin
      t      = vecs[v];
      m_nack = t.nack;
      m_stuck = t.stuck;
      chk("ready_before", cmd_ready, 1);
      base      = bus_n;
      cmd_rw    = t.rw;
      cmd_dev   = t.dev;
      cmd_reg   = t.regad;
      cmd_wdata = t.wdata;
      cmd_len   = t.len;
      cmd_start = 1'b1;
      @(negedge clk_sys);
      cmd_start = 1'b0;
      // Scramble inputs: the command must already be latched.
      cmd_dev   = 7'h00;
      cmd_reg   = 8'hFF;
      cmd_wdata = 8'hEE;
      cmd_len   = 4'd1;
      chk("ready_after_accept", cmd_ready, 0);

      nvalid = 0; late = 0; got_done = 1'b0; done_err = 1'b0; was_reset = 1'b0;
      for (int c = 0; c < 3000 && !got_done && !was_reset; c++) begin
        if (rd_valid) begin
          if (nvalid < 16) begin
            cap_idx[nvalid]  = rd_idx;
            cap_data[nvalid] = rd_data;
          end
          nvalid++;
          if (done) late++;
        end
        if (done) begin
          got_done = 1'b1;
          done_err = err;
        end else begin
          if (c == t.poke) begin
            cmd_start = 1'b1; cmd_dev = 7'h22; cmd_reg = 8'hAA; cmd_rw = 1'b0; cmd_len = 4'd1;
          end else begin
            cmd_start = 1'b0;
          end
          if (t.rst_after >= 0 && nvalid == t.rst_after) begin
            cpu_resetn = 1'b0;
            was_reset  = 1'b1;
          end
          @(negedge clk_sys);
        end
      end
      cmd_start = 1'b0;

      chk("done_seen", got_done, t.exp_done);
      chk("bytes", nvalid, t.exp_bytes);
      for (int j = 0; j < nvalid && j < t.exp_bytes && j < 16; j++) begin
        chk("rd_idx", cap_idx[j], j);
        chk("rd_data", cap_data[j], (j + 1) * 17);
      end
      if (t.exp_rises >= 0) chk("rises", bus_n - base, t.exp_rises);
      if (bus_n > base) begin
        chk("b0_addr", log_addr[base % 64], t.dev);
        chk("b0_rw", log_rw[base % 64], 0);
        chk("b0_data", log_data[base % 64], t.regad);
      end
      if (t.exp_rises >= 2 && bus_n - base >= 2) begin
        chk("b1_rw", log_rw[(base + 1) % 64], t.rw);
        chk("b1_addr", log_addr[(base + 1) % 64], t.dev);
        if (!t.rw) chk("b1_data", log_data[(base + 1) % 64], t.wdata);
      end

      if (got_done) begin
        chk("err_at_done", done_err, t.exp_err);
        chk("rd_valid_with_done", late, 0);
        @(negedge clk_sys);
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", cmd_ready, 1);
        chk("err_held", err, t.exp_err);
        chk("ena_after_done", i2c_ena, 0);
      end

      if (was_reset) begin
        chk("mrst_ready", cmd_ready, 1);
        chk("mrst_ena", i2c_ena, 0);
        chk("mrst_addr", i2c_addr, 0);
        chk("mrst_rw", i2c_rw, 0);
        chk("mrst_data_wr", i2c_data_wr, 0);
        chk("mrst_rd_valid", rd_valid, 0);
        chk("mrst_rd_idx", rd_idx, 0);
        chk("mrst_rd_data", rd_data, 0);
        chk("mrst_err", err, 0);
        cnt_done = 0;
        if (done) cnt_done++;
        cpu_resetn = 1'b1;
        repeat (3) begin
          @(negedge clk_sys);
          if (done) cnt_done++;
        end
        chk("mrst_no_done", cnt_done, 0);
      end

      $display("cmd %0d: rw=%0d dev=%02h reg=%02h len=%0d rises=%0d bytes=%0d done=%0d err=%0d rst=%0d",
               v, t.rw, t.dev, t.regad, t.len, bus_n - base, nvalid, got_done, done_err, was_reset);

      // Let the bus model drain before the next command.
      m_stuck = 1'b0;
      m_nack  = 1'b0;
      for (int c = 0; c < 100 && i2c_busy; c++) @(negedge clk_sys);
      chk("bus_idle", i2c_busy, 0);
      @(negedge clk_sys);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
